// File: rtl/fwd_hazard_unit_if.sv
// Signal bundle between the ID stage (master) and fwd_hazard_unit (slave).
// The perf counter outputs exist only when FWD_HAZARD_PERF_EN is defined.
interface fwd_hazard_unit_if #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned ADDR_W     = 5
);
    localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

    logic [NUM_SRC*ADDR_W-1:0] fwd_src_addr_in;
    logic [NUM_SRC-1:0]        fwd_src_valid_in;
    logic                      fwd_issue_valid_in;
    logic [ADDR_W-1:0]         fwd_issue_rd_addr_in;
    logic                      fwd_issue_wen_in;
    logic                      fwd_issue_load_in;
    logic                      fwd_flush_in;
    logic [NUM_SRC*SEL_W-1:0]  fwd_mux_sel_out;
    logic                      fwd_stall_out;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] fwd_stall_cnt_out;
    logic [31:0] fwd_fwd_cnt_out;

    modport master (
        output fwd_src_addr_in, fwd_src_valid_in, fwd_issue_valid_in, fwd_issue_rd_addr_in,
               fwd_issue_wen_in, fwd_issue_load_in, fwd_flush_in,
        input  fwd_mux_sel_out, fwd_stall_out, fwd_stall_cnt_out, fwd_fwd_cnt_out
    );

    modport slave (
        input  fwd_src_addr_in, fwd_src_valid_in, fwd_issue_valid_in, fwd_issue_rd_addr_in,
               fwd_issue_wen_in, fwd_issue_load_in, fwd_flush_in,
        output fwd_mux_sel_out, fwd_stall_out, fwd_stall_cnt_out, fwd_fwd_cnt_out
    );
`else
    modport master (
        output fwd_src_addr_in, fwd_src_valid_in, fwd_issue_valid_in, fwd_issue_rd_addr_in,
               fwd_issue_wen_in, fwd_issue_load_in, fwd_flush_in,
        input  fwd_mux_sel_out, fwd_stall_out
    );

    modport slave (
        input  fwd_src_addr_in, fwd_src_valid_in, fwd_issue_valid_in, fwd_issue_rd_addr_in,
               fwd_issue_wen_in, fwd_issue_load_in, fwd_flush_in,
        output fwd_mux_sel_out, fwd_stall_out
    );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the Core101 pipeline.
// Define FWD_HAZARD_PERF_EN to add stall / forward performance counters.
module fwd_hazard_unit #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic             clock_in,
    input  logic             reset_in,
    fwd_hazard_unit_if.slave fwd
);
    localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0]             valid_q, valid_d;
    logic [NUM_STAGES-1:0]             wen_q, wen_d;
    logic [NUM_STAGES-1:0]             load_q, load_d;
    logic [NUM_STAGES-1:0][ADDR_W-1:0] rd_q, rd_d;

    logic [NUM_SRC-1:0][ADDR_W-1:0]     src_addr;
    logic [NUM_SRC-1:0][NUM_STAGES-1:0] match;
    logic [NUM_SRC-1:0]                 load_hazard;
    logic [NUM_SRC-1:0][SEL_W-1:0]      sel;
    logic                               stall;

    assign src_addr = fwd.fwd_src_addr_in;

    always_comb begin
        match = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                match[i][k] = fwd.fwd_src_valid_in[i] && (src_addr[i] != '0) &&
                              valid_q[k] && wen_q[k] && (rd_q[k] == src_addr[i]);
            end
        end
    end

    // Scan oldest to youngest so the youngest matching producer is the last to write.
    always_comb begin
        sel         = '0;
        load_hazard = '0;
        stall       = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
                if (match[i][k]) begin
                    sel[i]         = SEL_W'(k + 1);
                    load_hazard[i] = load_q[k] && (k < int'(LOAD_LAT));
                end
            end
            if (load_hazard[i]) begin
                sel[i] = '0;
                stall  = 1'b1;
            end
        end
    end

    assign fwd.fwd_mux_sel_out = sel;
    assign fwd.fwd_stall_out   = stall;

    always_comb begin
        valid_d[0] = fwd.fwd_issue_valid_in & ~stall & ~fwd.fwd_flush_in;
        rd_d[0]    = fwd.fwd_issue_rd_addr_in;
        wen_d[0]   = fwd.fwd_issue_wen_in;
        load_d[0]  = fwd.fwd_issue_load_in;
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
            wen_d[k]   = wen_q[k-1];
            load_d[k]  = load_q[k-1];
        end
        if (fwd.fwd_flush_in) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            valid_q <= '0;
            rd_q    <= '0;
            wen_q   <= '0;
            load_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            load_q  <= load_d;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        fwd_cnt_d   = fwd_cnt_q + {31'd0, |sel};
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign fwd.fwd_stall_cnt_out = stall_cnt_q;
    assign fwd.fwd_fwd_cnt_out   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, reset corner case, then random
// traffic checked against an issue-history model of in-flight producers.
module tb_fwd_hazard_unit;
    localparam int unsigned NS  = 2;
    localparam int unsigned NST = 3;
    localparam int unsigned AW  = 5;
    localparam int unsigned LL  = 1;
    localparam int unsigned SW  = 2;
    localparam int          NT  = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NUM_SRC(NS), .NUM_STAGES(NST), .ADDR_W(AW)) bus ();

    fwd_hazard_unit #(
        .NUM_SRC   (NS),
        .NUM_STAGES(NST),
        .ADDR_W    (AW),
        .LOAD_LAT  (LL)
    ) dut (
        .clock_in(clk),
        .reset_in(rst_n),
        .fwd     (bus)
    );

    typedef struct {
        logic          iv;
        logic [AW-1:0] rd;
        logic          wen;
        logic          ld;
        logic          fl;
        logic [AW-1:0] s0;
        logic [AW-1:0] s1;
        logic [NS-1:0] sv;
        logic [SW-1:0] e0;
        logic [SW-1:0] e1;
        logic          est;
    } vec_t;

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] rd;
        logic          wen;
        logic          ld;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Model: every accepted issue is remembered with the cycle it issued in.
    ent_t          hist[$];
    int unsigned   now_cyc = 0;
    logic [SW-1:0] exp_sel[NS];
    logic          exp_stall;
    logic [31:0]   m_stall_cnt = 0;
    logic [31:0]   m_fwd_cnt = 0;

    vec_t tab[NT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input int rd, input logic wen, input logic ld,
                                input logic fl, input int s0, input int s1, input logic [1:0] sv,
                                input int e0, input int e1, input logic est);
        vec_t v;
        v.iv = iv;  v.rd = AW'(rd); v.wen = wen; v.ld = ld; v.fl = fl;
        v.s0 = AW'(s0); v.s1 = AW'(s1); v.sv = sv;
        v.e0 = SW'(e0); v.e1 = SW'(e1); v.est = est;
        return v;
    endfunction

    // A producer issued in cycle c sits in stage (now - c - 1); pick the youngest match.
    function automatic void model_eval(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                       input logic [NS-1:0] v);
        logic [AW-1:0] addr;
        exp_stall = 1'b0;
        for (int i = 0; i < int'(NS); i++) begin
            int   best = -1;
            logic bld = 1'b0;
            addr = (i == 0) ? a0 : a1;
            if (addr != 0 && v[i]) begin
                foreach (hist[j]) begin
                    int age = int'(now_cyc - hist[j].cyc) - 1;
                    if (hist[j].wen && hist[j].rd == addr && age >= 0 && age < int'(NST) &&
                        (best < 0 || age < best)) begin
                        best = age;
                        bld  = hist[j].ld;
                    end
                end
            end
            exp_sel[i] = (best < 0) ? '0 : SW'(best + 1);
            if (best >= 0 && bld && best < int'(LL)) begin
                exp_stall  = 1'b1;
                exp_sel[i] = '0;
            end
        end
    endfunction

    function automatic void model_update(input vec_t v);
        if (exp_stall) m_stall_cnt++;
        if (exp_sel[0] != 0 || exp_sel[1] != 0) m_fwd_cnt++;
        if (v.fl) hist.delete();
        else if (v.iv && !exp_stall) hist.push_back('{now_cyc, v.rd, v.wen, v.ld});
        now_cyc++;
        while (hist.size() > 0 && int'(now_cyc - hist[0].cyc) - 1 >= int'(NST)) void'(hist.pop_front());
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endfunction

    task automatic drive(input vec_t v);
        bus.fwd_issue_valid_in   = v.iv;
        bus.fwd_issue_rd_addr_in = v.rd;
        bus.fwd_issue_wen_in     = v.wen;
        bus.fwd_issue_load_in    = v.ld;
        bus.fwd_flush_in         = v.fl;
        bus.fwd_src_addr_in      = {v.s1, v.s0};
        bus.fwd_src_valid_in     = v.sv;
    endtask

    task automatic step(input vec_t v, input bit use_tab, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        model_eval(v.s0, v.s1, v.sv);
        for (int i = 0; i < int'(NS); i++) begin
            chk($sformatf("%s model sel%0d", tag, i), 32'(bus.fwd_mux_sel_out[i*SW +: SW]),
                32'(exp_sel[i]));
        end
        chk({tag, " model stall"}, 32'(bus.fwd_stall_out), 32'(exp_stall));
        if (use_tab) begin
            chk({tag, " sel0"}, 32'(bus.fwd_mux_sel_out[SW-1:0]), 32'(v.e0));
            chk({tag, " sel1"}, 32'(bus.fwd_mux_sel_out[2*SW-1:SW]), 32'(v.e1));
            chk({tag, " stall"}, 32'(bus.fwd_stall_out), 32'(v.est));
        end
        @(posedge clk);
        model_update(v);
    endtask

    task automatic check_counters(input string tag);
`ifdef FWD_HAZARD_PERF_EN
        chk({tag, " stall_cnt"}, bus.fwd_stall_cnt_out, m_stall_cnt);
        chk({tag, " fwd_cnt"}, bus.fwd_fwd_cnt_out, m_fwd_cnt);
`else
        if (tag.len() == 0) $display("no counters");
`endif
    endtask

    initial begin
        vec_t v;
        // iv rd wen ld fl | s0 s1 sv | e0 e1 stall
        tab[0]  = mk(1, 5, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[1]  = mk(0, 0, 0, 0, 0,  5, 0, 2'b11, 1, 0, 0);
        tab[2]  = mk(0, 0, 0, 0, 0,  5, 0, 2'b01, 2, 0, 0);
        tab[3]  = mk(0, 0, 0, 0, 0,  5, 0, 2'b01, 3, 0, 0);
        tab[4]  = mk(0, 0, 0, 0, 0,  5, 0, 2'b01, 0, 0, 0);
        tab[5]  = mk(1, 7, 1, 1, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[6]  = mk(1, 8, 1, 0, 0,  0, 7, 2'b10, 0, 0, 1);
        tab[7]  = mk(1, 8, 1, 0, 0,  0, 7, 2'b10, 0, 2, 0);
        tab[8]  = mk(0, 0, 0, 0, 0,  8, 7, 2'b11, 1, 3, 0);
        tab[9]  = mk(1, 3, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[10] = mk(1, 4, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[11] = mk(1, 3, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[12] = mk(0, 0, 0, 0, 0,  3, 4, 2'b11, 1, 2, 0);
        tab[13] = mk(1, 0, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[14] = mk(0, 0, 0, 0, 0,  0, 0, 2'b11, 0, 0, 0);
        tab[15] = mk(1, 9, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[16] = mk(1, 9, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[17] = mk(1, 9, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[18] = mk(1, 9, 1, 0, 1,  9, 0, 2'b01, 1, 0, 0);
        tab[19] = mk(0, 0, 0, 0, 0,  9, 0, 2'b01, 0, 0, 0);
        tab[20] = mk(1, 6, 1, 0, 0,  0, 0, 2'b00, 0, 0, 0);
        tab[21] = mk(0, 0, 0, 0, 0,  6, 6, 2'b10, 0, 1, 0);
        tab[22] = mk(1, 10, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tab[23] = mk(1, 10, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        tab[24] = mk(0, 0, 0, 0, 0,  10, 0, 2'b01, 0, 0, 1);
        tab[25] = mk(0, 0, 0, 0, 0,  10, 0, 2'b01, 2, 0, 0);
        tab[26] = mk(1, 11, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tab[27] = mk(0, 0, 0, 0, 0,  11, 0, 2'b01, 0, 0, 0);
        tab[28] = mk(1, 13, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        tab[29] = mk(1, 14, 1, 0, 1, 13, 0, 2'b01, 0, 0, 1);
        tab[30] = mk(0, 0, 0, 0, 0,  13, 0, 2'b01, 0, 0, 0);

        drive(mk(0, 0, 0, 0, 0, 5, 5, 2'b11, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset sel", 32'(bus.fwd_mux_sel_out), 32'd0);
        chk("reset stall", 32'(bus.fwd_stall_out), 32'd0);
        check_counters("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < NT; n++) begin
            step(tab[n], 1'b1, $sformatf("vec%0d", n));
        end
        check_counters("table");

        // Reset pulse while a load-use stall is being asserted.
        step(mk(1, 12, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0), 1'b0, "mid_issue");
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 12, 0, 2'b01, 0, 0, 0));
        #1;
        chk("mid stall before reset", 32'(bus.fwd_stall_out), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid stall in reset", 32'(bus.fwd_stall_out), 32'd0);
        chk("mid sel in reset", 32'(bus.fwd_mux_sel_out), 32'd0);
        check_counters("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 12, 0, 2'b01, 0, 0, 0), 1'b1, "after reset");

        for (int n = 0; n < 400; n++) begin
            v.iv  = ($urandom_range(0, 3) != 0);
            v.rd  = AW'($urandom_range(0, 3));
            v.wen = ($urandom_range(0, 4) != 0);
            v.ld  = ($urandom_range(0, 2) == 0);
            v.fl  = ($urandom_range(0, 19) == 0);
            v.s0  = AW'($urandom_range(0, 3));
            v.s1  = AW'($urandom_range(0, 3));
            v.sv  = NS'($urandom_range(0, 3));
            v.e0 = '0; v.e1 = '0; v.est = 1'b0;
            step(v, 1'b0, $sformatf("rnd%0d", n));
        end
        check_counters("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
